// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencer: state encoding and default width.
package counter_seq_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

endpackage

// File: rtl/counter_seq_ctrl_ctr.sv
// Counter datapath: clear beats load beats increment; tc flags the all-ones value.
module ctr_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             ce,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

    // count register with prioritised clear/load/increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= ZERO;
        end else if (clear) begin
            q <= ZERO;
        end else if (load) begin
            q <= d;
        end else if (ce) begin
            q <= q + ONE;
        end else begin
            q <= q;
        end
    end

    assign tc = (q == ONES);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Job sequencer: accepts a count job, runs it through reps+1 passes to all-ones,
// and reports normal completion or a stop-initiated abort with one-cycle pulses.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] reps,
    input  logic             ce,
    input  logic             stop,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] reps_left_r;
    logic [WIDTH-1:0] load_cap_r;
    logic [WIDTH-1:0] load_data_s;
    logic             core_load_s;
    logic             core_inc_s;
    logic             core_clear_s;
    logic             capture_s;
    logic             reps_dec_s;
    logic [WIDTH-1:0] core_q_s;
    logic             core_tc_s;

    ctr_core #(.WIDTH(WIDTH)) u_ctr_core (
        .clk   (clk),
        .rst   (rst),
        .load  (core_load_s),
        .d     (load_data_s),
        .ce    (core_inc_s),
        .clear (core_clear_s),
        .q     (core_q_s),
        .tc    (core_tc_s)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // job parameters captured at acceptance; later input changes have no effect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reps_left_r <= ZERO;
            load_cap_r  <= ZERO;
        end else if (capture_s) begin
            reps_left_r <= reps;
            load_cap_r  <= load_val;
        end else if (reps_dec_s) begin
            reps_left_r <= reps_left_r - ONE;
        end else begin
            reps_left_r <= reps_left_r;
        end
    end

    // next-state and datapath control; stop outranks terminal count and reload
    always_comb begin
        next_state_s = state_r;
        load_data_s  = load_cap_r;
        core_load_s  = 1'b0;
        core_inc_s   = 1'b0;
        core_clear_s = 1'b0;
        capture_s    = 1'b0;
        reps_dec_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = ST_COUNT;
                    capture_s    = 1'b1;
                    core_load_s  = 1'b1;
                    load_data_s  = load_val;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (stop) begin
                    next_state_s = ST_ABORT;
                end else if (ce) begin
                    if (!core_tc_s) begin
                        core_inc_s = 1'b1;
                    end else if (reps_left_r != ZERO) begin
                        core_load_s = 1'b1;
                        reps_dec_s  = 1'b1;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_COUNT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            ST_ABORT: begin
                core_clear_s = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign cnt       = core_q_s;
    assign req_ready = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_COUNT) || (state_r == ST_DONE);
    assign done      = (state_r == ST_DONE);
    assign aborted   = (state_r == ST_ABORT);
    assign tc        = (state_r == ST_COUNT) && core_tc_s;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// and randomized traffic against an arithmetic job-progress model.
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] load_val = 4'd0;
    logic [3:0] reps = 4'd0;
    logic       ce = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] cnt;
    logic       tc, busy, done, aborted;

    int n_vec = 0;
    int n_err = 0;

    counter_seq_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .load_val(load_val), .reps(reps), .ce(ce), .stop(stop),
        .cnt(cnt), .tc(tc), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rv; logic [3:0] lv; logic [3:0] rp; logic ce; logic st;
        logic [3:0] cnt; logic tc; logic busy; logic done; logic ab; logic rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rv, int lv, int rp, logic c, logic st, int ec,
                               logic etc, logic eb, logic ed, logic ea, logic er);
        vec_t r;
        r.rv = rv; r.lv = 4'(lv); r.rp = 4'(rp); r.ce = c; r.st = st;
        r.cnt = 4'(ec); r.tc = etc; r.busy = eb; r.done = ed; r.ab = ea; r.rdy = er;
        return r;
    endfunction

    // Reference model: phase 0 idle, 1 count, 2 done, 3 abort.
    // In COUNT the value is load + (k mod pass_len), k = enabled cycles so far;
    // the job ends at the enabled cycle where k reaches (reps+1)*pass_len - 1.
    int m_phase, m_cnt, m_load, m_reps, m_len, m_k;

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_load = 0; m_reps = 0; m_len = 16; m_k = 0;
    endtask

    task automatic model_step(logic rv, int lv, int rp, logic c, logic st);
        case (m_phase)
            0: if (rv) begin
                m_load = lv; m_reps = rp; m_len = 16 - lv; m_k = 0;
                m_cnt = lv; m_phase = 1;
            end
            1: if (st) m_phase = 3;
               else if (c) begin
                   if (m_k == (m_reps + 1) * m_len - 1) m_phase = 2;
                   else begin
                       m_k++;
                       m_cnt = m_load + (m_k % m_len);
                   end
               end
            2: m_phase = 0;
            default: begin m_phase = 0; m_cnt = 0; end
        endcase
    endtask

    task automatic drive_edge(logic rv, int lv, int rp, logic c, logic st);
        req_valid = rv; load_val = 4'(lv); reps = 4'(rp); ce = c; stop = st;
        @(posedge clk);
        model_step(rv, lv, rp, c, st);
        @(negedge clk);
    endtask

    task automatic compare(string name, logic [8:0] exp);
        logic [8:0] got;
        got = {cnt, tc, busy, done, aborted, req_ready};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got cnt=%0d tc=%b busy=%b done=%b aborted=%b ready=%b, want cnt=%0d tc=%b busy=%b done=%b aborted=%b ready=%b",
                     name, got[8:5], got[4], got[3], got[2], got[1], got[0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_model(string name);
        logic [8:0] exp;
        exp = {4'(m_cnt), (m_phase == 1) && (m_cnt == 15), (m_phase == 1) || (m_phase == 2),
               m_phase == 2, m_phase == 3, m_phase == 0};
        compare(name, exp);
    endtask

    task automatic check_int(string name, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    initial begin
        int n_count, n_done, holds;
        logic ce_v;

        // load 12 single pass
        tbl.push_back(v(1,12,0,1,0, 12,0,1,0,0,0));
        tbl.push_back(v(0, 0,0,1,0, 13,0,1,0,0,0));
        tbl.push_back(v(0, 0,0,1,0, 14,0,1,0,0,0));
        tbl.push_back(v(0, 0,0,1,0, 15,1,1,0,0,0));
        tbl.push_back(v(0, 0,0,1,0, 15,0,1,1,0,0));
        tbl.push_back(v(0, 0,0,1,0, 15,0,0,0,0,1));
        // load 14, reps 2, inputs scribbled after acceptance
        tbl.push_back(v(1,14,2,1,0, 14,0,1,0,0,0));
        tbl.push_back(v(0, 3,7,1,0, 15,1,1,0,0,0));
        tbl.push_back(v(0, 3,7,1,0, 14,0,1,0,0,0));
        tbl.push_back(v(0, 3,7,1,0, 15,1,1,0,0,0));
        tbl.push_back(v(0, 3,7,1,0, 14,0,1,0,0,0));
        tbl.push_back(v(0, 3,7,1,0, 15,1,1,0,0,0));
        tbl.push_back(v(0, 3,7,1,0, 15,0,1,1,0,0));
        tbl.push_back(v(0, 3,7,1,0, 15,0,0,0,0,1));
        // load 13, reps 1, stop on the terminal cycle
        tbl.push_back(v(1,13,1,1,0, 13,0,1,0,0,0));
        tbl.push_back(v(0, 0,0,1,0, 14,0,1,0,0,0));
        tbl.push_back(v(0, 0,0,1,0, 15,1,1,0,0,0));
        tbl.push_back(v(0, 0,0,1,1, 15,0,0,0,1,0));
        tbl.push_back(v(0, 0,0,1,0,  0,0,0,0,0,1));
        tbl.push_back(v(0, 5,0,1,1,  0,0,0,0,0,1));
        // req_valid held high across a job
        tbl.push_back(v(1,14,0,1,0, 14,0,1,0,0,0));
        tbl.push_back(v(1, 3,0,1,0, 15,1,1,0,0,0));
        tbl.push_back(v(1, 3,0,1,0, 15,0,1,1,0,0));
        tbl.push_back(v(1,10,0,1,0, 15,0,0,0,0,1));
        tbl.push_back(v(1,10,0,1,0, 10,0,1,0,0,0));
        tbl.push_back(v(0, 0,0,0,0, 10,0,1,0,0,0));
        tbl.push_back(v(0, 0,0,1,1, 10,0,0,0,1,0));
        tbl.push_back(v(0, 0,0,1,0,  0,0,0,0,0,1));
        // load all-ones, one reload
        tbl.push_back(v(1,15,1,1,0, 15,1,1,0,0,0));
        tbl.push_back(v(0, 0,0,1,0, 15,1,1,0,0,0));
        tbl.push_back(v(0, 0,0,1,0, 15,0,1,1,0,0));
        tbl.push_back(v(0, 0,0,1,0, 15,0,0,0,0,1));

        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare("reset_state", 9'b0000_0_0_0_0_1);
        rst = 1'b0;
        @(negedge clk);
        compare("after_reset", 9'b0000_0_0_0_0_1);

        foreach (tbl[i]) begin
            drive_edge(tbl[i].rv, int'(tbl[i].lv), int'(tbl[i].rp), tbl[i].ce, tbl[i].st);
            compare($sformatf("tbl_%0d", i),
                    {tbl[i].cnt, tbl[i].tc, tbl[i].busy, tbl[i].done, tbl[i].ab, tbl[i].rdy});
        end

        // load 0 with ce held low three cycles at cnt 5: 19 count cycles, one done
        n_count = 0; n_done = 0; holds = 0;
        drive_edge(1, 0, 0, 1'b1, 1'b0);
        check_model("hold_start");
        for (int i = 0; i < 60; i++) begin
            if (busy && !done) n_count++;
            if (done) n_done++;
            if (req_ready) break;
            ce_v = 1'b1;
            if (m_phase == 1 && m_cnt == 5 && holds < 3) begin
                ce_v = 1'b0;
                holds++;
            end
            drive_edge(0, 0, 0, ce_v, 1'b0);
            check_model("hold_step");
        end
        check_int("hold_count_cycles", n_count, 19);
        check_int("hold_done_pulses", n_done, 1);

        // asynchronous reset at cnt 9
        drive_edge(1, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) drive_edge(0, 0, 0, 1'b1, 1'b0);
        check_model("pre_reset_cnt9");
        #2 rst = 1'b1;
        #1 compare("async_reset", 9'b0000_0_0_0_0_1);
        @(negedge clk);
        compare("reset_held", 9'b0000_0_0_0_0_1);
        rst = 1'b0;
        model_reset();
        drive_edge(1, 7, 0, 1'b1, 1'b0);
        check_model("post_reset_accept");
        drive_edge(0, 0, 0, 1'b1, 1'b0);
        check_model("post_reset_count");

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            drive_edge(($urandom % 3) == 0,
                       ($urandom % 4 == 0) ? int'($urandom % 16) : int'($urandom_range(10, 15)),
                       int'($urandom % 4),
                       ($urandom % 4) != 0,
                       ($urandom % 16) == 0);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set counter and load/repeat field width.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 req_valid  input  1  SHALL mean a count job is offered.
REQ-005 req_ready  output  1  SHALL mean the block accepts a job this cycle.
REQ-006 load_val  input  WIDTH  SHALL be the job start value.
REQ-007 reps  input  WIDTH  SHALL be the job reload count (0 = single pass).
REQ-008 ce  input  1  SHALL be count enable; low holds the count.
REQ-009 stop  input  1  SHALL abort a running job.
REQ-010 cnt  output  WIDTH  SHALL be the current counter value.
REQ-011 tc  output  1  SHALL be terminal count: cnt all-ones while COUNT.
REQ-012 busy  output  1  SHALL be high in COUNT and DONE.
REQ-013 done  output  1  SHALL be a one-cycle pulse on normal job completion.
REQ-014 aborted  output  1  SHALL be a one-cycle pulse on stop-terminated job.

Function
REQ-015 States SHALL be IDLE, COUNT, DONE, ABORT.
REQ-016 req_ready SHALL equal (state==IDLE); no other state accepts.
REQ-017 IDLE, req_valid high at edge: SHALL capture reps into reps_left, load cnt<=load_val, go COUNT.
REQ-018 COUNT, ce high, cnt != all-ones: cnt SHALL increment by 1.
REQ-019 COUNT, ce low: cnt, reps_left, state SHALL hold; tc still reflects cnt.
REQ-020 COUNT, ce high, cnt all-ones, reps_left>0: SHALL reload cnt<=load_val (captured copy), reps_left decrements.
REQ-021 COUNT, ce high, cnt all-ones, reps_left==0: SHALL go DONE, cnt holds all-ones.
REQ-022 DONE SHALL last exactly one cycle with done=1, then IDLE with cnt held.
REQ-023 COUNT, stop high: SHALL go ABORT regardless of ce or tc (stop wins over terminal/reload).
REQ-024 ABORT SHALL last one cycle with aborted=1, cnt cleared to 0 at exit to IDLE.
REQ-025 stop outside COUNT SHALL be ignored; load_val/reps changes after acceptance SHALL be ignored.
REQ-026 Job length with ce constantly high SHALL be (reps+1)*(2^WIDTH - load_val) COUNT cycles.
REQ-027 load_val all-ones SHALL give one COUNT cycle per pass (tc on first cycle).
REQ-028 Increment SHALL be modulo 2^WIDTH; no wrap occurs in COUNT since all-ones always reloads or exits.

Reset
REQ-029 rst high SHALL immediately force state IDLE, cnt=0, reps_left=0, captured load_val=0.
REQ-030 During and after reset: tc=0, busy=0, done=0, aborted=0, req_ready=1 after rst deasserts.
REQ-031 Reset mid-job SHALL discard the job with no done or aborted pulse.

Structure
REQ-032 Shared package SHALL hold the state encoding constants and default WIDTH.
REQ-033 Counter datapath SHALL be sub-module ctr_core (load, ce, clear, q, tc) instantiated once; FSM in counter_seq_ctrl.

Verification
REQ-034 load_val=12, reps=0, ce=1 -> cnt 12,13,14,15 (tc on 15), done pulse next cycle, req_ready 1 cycle after.
REQ-035 load_val=14, reps=2, ce=1 -> cnt 14,15,14,15,14,15, then done; 6 COUNT cycles total.
REQ-036 load_val=0, ce low for 3 cycles at cnt=5 -> cnt stays 5 three cycles, total COUNT cycles 19, done once.
REQ-037 load_val=13, stop asserted in cycle cnt=15 with reps=1 -> ABORT, aborted pulse, no reload, no done, cnt=0 in IDLE.
REQ-038 rst asserted asynchronously mid-COUNT (cnt=9) -> cnt=0, busy=0 without clock edge; no done/aborted; next req_valid accepted normally.
REQ-039 req_valid held high through job -> second job accepted only in first IDLE cycle after DONE.
